// File: rtl/noc_types.sv
// noc_types: types shared across the NoC blocks
package noc_types;
  typedef logic [7:0] addr_t;
endpackage

// File: rtl/noc_rr_picker.sv
// noc_rr_picker: combinational round-robin pick, lowest index at or after ptr wins
module noc_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  localparam logic [IDX_W:0] N = (IDX_W + 1)'(N_REQ);
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= N) ? IDX_W'(sum - N) : sum[IDX_W-1:0];
  end
  assign valid = |req;
endmodule

// File: rtl/noc_sender_arbiter.sv
// noc_sender_arbiter: round-robin owner of one serial packet sender, grant held
// from header through tail, one-cycle done pulse on the sender's ack
module noc_sender_arbiter
  import noc_types::*;
#(
  parameter int N_REQ        = 4,
  parameter int PACKET_BITS  = 16,
  parameter int PADDING_BITS = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  addr_t                   dst_addr [N_REQ],
  input  logic [PADDING_BITS-1:0] padding  [N_REQ],
  input  logic [PACKET_BITS-1:0]  packet   [N_REQ],
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    busy,
  output logic [IDX_W-1:0]        cur_idx,
  output logic                    snd_enable,
  output addr_t                   snd_dst_addr,
  output logic [PADDING_BITS-1:0] snd_padding,
  output logic [PACKET_BITS-1:0]  snd_packet,
  input  logic                    snd_ack
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  noc_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req(req), .ptr(ptr), .valid(pick_valid), .idx(pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      grant   <= '0;
      cur_idx <= '0;
      ptr     <= '0;
    end else if (state == IDLE) begin
      if (pick_valid) begin
        state   <= BUSY;
        grant   <= N_REQ'(1) << pick_idx;
        cur_idx <= pick_idx;
      end
    end else if (snd_ack) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= (cur_idx == IDX_W'(N_REQ - 1)) ? '0 : cur_idx + 1'b1;
    end
  end

  // enable drops in the ack cycle so the sender does not restart from SENT
  assign busy         = state == BUSY;
  assign done         = (busy && snd_ack) ? grant : '0;
  assign snd_enable   = busy && !snd_ack;
  assign snd_dst_addr = busy ? dst_addr[cur_idx] : '0;
  assign snd_padding  = busy ? padding[cur_idx] : '0;
  assign snd_packet   = busy ? packet[cur_idx] : '0;

  a_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant) && $onehot0(done));
  a_done_owner: assert property (@(posedge clk) disable iff (!rst) (done & ~grant) == '0);
  a_busy_grant: assert property (@(posedge clk) disable iff (!rst) (|grant) == busy);
endmodule

// File: tb/tb_noc_sender_arbiter.sv
// tb_noc_sender_arbiter: directed vector table, async reset sequence, random run vs. model
module tb_noc_sender_arbiter;
  import noc_types::*;
  logic clk = 0, rst = 0, snd_ack = 0;
  logic [3:0] req = '0, grant, done;
  addr_t dst_addr [4];
  logic [3:0] padding [4];
  logic [15:0] packet [4];
  logic busy, snd_enable;
  logic [1:0] cur_idx;
  addr_t snd_dst_addr;
  logic [3:0] snd_padding;
  logic [15:0] snd_packet;
  int nvec = 0, nbad = 0;

  always #5 clk = ~clk;

  noc_sender_arbiter #(.N_REQ(4), .PACKET_BITS(16), .PADDING_BITS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .dst_addr(dst_addr), .padding(padding),
    .packet(packet), .grant(grant), .done(done), .busy(busy), .cur_idx(cur_idx),
    .snd_enable(snd_enable), .snd_dst_addr(snd_dst_addr), .snd_padding(snd_padding),
    .snd_packet(snd_packet), .snd_ack(snd_ack)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] eg, ed;
    logic       eb, ee;
    logic [1:0] ei;
  } vec_t;
  vec_t vecs[$];

  task automatic push(input logic r, input logic [3:0] rq, input logic a,
                      input logic [3:0] eg, input logic [3:0] ed,
                      input logic eb, input logic ee, input logic [1:0] ei);
    vec_t v;
    v = '{r, rq, a, eg, ed, eb, ee, ei};
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [3:0] rq, input logic [1:0] last);
    push(1, rq, 0, 4'b0, 4'b0, 0, 0, last);
  endtask

  // n busy cycles holding req, then the ack cycle with req_ack
  task automatic serve(input logic [3:0] rq, input logic [3:0] rq_ack, input int owner, input int n);
    for (int k = 0; k < n; k++) push(1, rq, 0, 4'b1 << owner, 4'b0, 1, 1, 2'(owner));
    push(1, rq_ack, 1, 4'b1 << owner, 4'b1 << owner, 1, 0, 2'(owner));
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [39:0] act, exp;
  int m_owner, mptr, cnt;
  logic m_busy;

  initial begin
    for (int i = 0; i < 4; i++) begin
      dst_addr[i] = addr_t'(8'h10 + i);
      padding[i]  = 4'(i + 1);
      packet[i]   = 16'hA000 + 16'(i);
    end
    dst_addr[2] = 8'h05;
    packet[2]   = 16'hBEEF;

    push(0, 4'b0000, 0, 4'b0, 4'b0, 0, 0, 0);
    idle(4'b0100, 0);
    serve(4'b0100, 4'b0100, 2, 5);
    idle(4'b0000, 2);
    push(1, 4'b0000, 1, 4'b0, 4'b0, 0, 0, 2);
    idle(4'b0000, 2);
    idle(4'b0001, 2);
    push(1, 4'b0001, 0, 4'b0001, 4'b0, 1, 1, 0);
    push(1, 4'b0001, 0, 4'b0001, 4'b0, 1, 1, 0);
    push(0, 4'b0001, 0, 4'b0, 4'b0, 0, 0, 0);
    idle(4'b0010, 0);
    serve(4'b0010, 4'b0010, 1, 2);
    idle(4'b1001, 1);
    serve(4'b1001, 4'b1001, 3, 2);
    idle(4'b1001, 3);
    serve(4'b1001, 4'b1001, 0, 2);
    idle(4'b0000, 0);
    push(0, 4'b0000, 0, 4'b0, 4'b0, 0, 0, 0);
    idle(4'b1111, 0);
    for (int k = 0; k < 8; k++) begin
      serve(4'b1111, 4'b1111, k % 4, 1);
      idle(k == 7 ? 4'b0000 : 4'b1111, 2'(k % 4));
    end
    idle(4'b0010, 3);
    serve(4'b0000, 4'b0110, 1, 3);
    idle(4'b0110, 1);
    serve(4'b0110, 4'b0110, 2, 1);
    idle(4'b0110, 2);
    serve(4'b0110, 4'b0000, 1, 1);
    idle(4'b0000, 1);

    foreach (vecs[n]) begin
      @(negedge clk);
      rst = vecs[n].rst; req = vecs[n].req; snd_ack = vecs[n].ack;
      #1;
      act = {grant, done, busy, snd_enable, cur_idx, snd_packet, snd_dst_addr, snd_padding};
      exp = {vecs[n].eg, vecs[n].ed, vecs[n].eb, vecs[n].ee, vecs[n].ei,
             vecs[n].eb ? packet[vecs[n].ei] : 16'h0,
             vecs[n].eb ? dst_addr[vecs[n].ei] : 8'h0,
             vecs[n].eb ? padding[vecs[n].ei] : 4'h0};
      check($sformatf("vec%0d", n), act, exp);
    end

    // reset asserted between edges must clear outputs without waiting for a clock
    @(negedge clk); rst = 1; req = 4'b0001; snd_ack = 0;
    @(negedge clk); #1;
    check("busy_before_reset", {36'h0, busy, 3'h0}, {36'h0, 1'b1, 3'h0});
    @(posedge clk); #2 rst = 0; #1;
    check("async_reset", {grant, done, busy, snd_enable, cur_idx, snd_packet, snd_dst_addr, snd_padding}, 40'h0);
    @(negedge clk); rst = 1; req = 4'b0000;

    m_busy = 0; mptr = 0; m_owner = 0; cnt = 2;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if (snd_ack) snd_ack = 0;
      else if (busy) begin
        if (cnt == 0) begin snd_ack = 1; cnt = $urandom_range(0, 5); end
        else cnt--;
      end else snd_ack = ($urandom_range(0, 7) == 0);
      #1;
      check($sformatf("rand%0d", c), {32'h0, grant, done},
            {32'h0, m_busy ? 4'b1 << m_owner : 4'b0, (m_busy && snd_ack) ? 4'b1 << m_owner : 4'b0});
      if (!m_busy && |req) begin m_owner = rr_pick(req, mptr); m_busy = 1; end
      else if (m_busy && snd_ack) begin m_busy = 0; mptr = (m_owner + 1) % 4; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
